// File: rtl/lfsr_bert_sequencer.sv
// Test sequencer for an LFSR generator/checker pair: seeds the generator, drives a
// programmable valid pattern, waits for checker lock and scores a monitor window.
//   state   | meaning
//   IDLE    | waiting for start, generator quiet
//   SEED    | soft reset held while the generator loads the seed
//   ACQUIRE | pattern running, waiting for checker lock or timeout
//   MONITOR | pattern running, counting lock losses over the run window
//   DONE    | one-cycle result publication
module lfsr_bert_sequencer #(
  parameter int LFSR_WIDTH   = 8,
  parameter int SEED_CYCLES  = 10,
  parameter int LOCK_TIMEOUT = 512,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  input  logic [3:0]            i_valid_on,
  input  logic [3:0]            i_valid_off,
  input  logic [CNT_WIDTH-1:0]  i_run_cycles,
  input  logic                  i_lock,
  output logic [LFSR_WIDTH-1:0] o_seed,
  output logic                  o_soft_reset,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [CNT_WIDTH-1:0]  o_loss_cnt
);

  localparam int SEED_W = $clog2(SEED_CYCLES + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int MAX_ST = (SEED_W > TO_W) ? SEED_W : TO_W;
  localparam int TMR_W  = (CNT_WIDTH > MAX_ST) ? CNT_WIDTH : MAX_ST;

  localparam logic [TMR_W-1:0] SEED_LOAD = TMR_W'(SEED_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_ACQUIRE,
    S_MONITOR,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0]     tmr;
  logic                 tmr_zero;
  logic [3:0]           on_cfg;
  logic [3:0]           off_cfg;
  logic [CNT_WIDTH-1:0] run_cfg;
  logic [3:0]           pat_cnt;
  logic                 lock_d;
  logic                 loss_evt;
  logic                 pass_nxt;
  logic                 start_evt;
  logic                 pat_start;
  logic                 pat_run;

  assign tmr_zero = (tmr == '0);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start && !i_abort) state_nxt = S_SEED;
      end
      S_SEED: begin
        if (i_abort)       state_nxt = S_IDLE;
        else if (tmr_zero) state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        // lock wins over a timeout landing on the same cycle
        if (i_abort)       state_nxt = S_IDLE;
        else if (i_lock)   state_nxt = S_MONITOR;
        else if (tmr_zero) state_nxt = S_DONE;
      end
      S_MONITOR: begin
        if (i_abort)       state_nxt = S_IDLE;
        else if (tmr_zero) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_evt = (state == S_IDLE) && (state_nxt == S_SEED);
    pat_start = (state == S_SEED) && (state_nxt == S_ACQUIRE);
    pat_run   = ((state == S_ACQUIRE) || (state == S_MONITOR)) &&
                ((state_nxt == S_ACQUIRE) || (state_nxt == S_MONITOR));
    loss_evt  = (state == S_MONITOR) && !i_abort && !i_lock && lock_d;
    pass_nxt  = (o_loss_cnt == '0) && i_lock;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      tmr          <= '0;
      on_cfg       <= 4'd1;
      off_cfg      <= 4'd0;
      run_cfg      <= '0;
      pat_cnt      <= 4'd0;
      lock_d       <= 1'b0;
      o_seed       <= '1;
      o_soft_reset <= 1'b0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_loss_cnt   <= '0;
    end else begin
      lock_d       <= i_lock;
      o_busy       <= (state_nxt != S_IDLE);
      o_soft_reset <= (state_nxt == S_SEED);
      o_done       <= (state_nxt == S_DONE);

      if (start_evt) begin
        // an all-zero seed would lock the LFSR up
        o_seed     <= (i_seed == '0) ? '1 : i_seed;
        on_cfg     <= (i_valid_on == 4'd0) ? 4'd1 : i_valid_on;
        off_cfg    <= i_valid_off;
        run_cfg    <= (i_run_cycles == '0) ? CNT_WIDTH'(1) : i_run_cycles;
        o_pass     <= 1'b0;
        o_loss_cnt <= '0;
      end else if (loss_evt && (o_loss_cnt != '1)) begin
        o_loss_cnt <= o_loss_cnt + CNT_WIDTH'(1);
      end

      if (state_nxt != state) begin
        case (state_nxt)
          S_SEED:    tmr <= SEED_LOAD;
          S_ACQUIRE: tmr <= TO_LOAD;
          S_MONITOR: tmr <= TMR_W'(run_cfg - CNT_WIDTH'(1));
          default:   tmr <= '0;
        endcase
      end else if (!tmr_zero) begin
        tmr <= tmr - TMR_W'(1);
      end

      if (pat_start) begin
        o_valid <= 1'b1;
        pat_cnt <= on_cfg - 4'd1;
      end else if (pat_run) begin
        if (off_cfg == 4'd0) begin
          o_valid <= 1'b1;
        end else if (pat_cnt == 4'd0) begin
          o_valid <= !o_valid;
          pat_cnt <= o_valid ? (off_cfg - 4'd1) : (on_cfg - 4'd1);
        end else begin
          pat_cnt <= pat_cnt - 4'd1;
        end
      end else begin
        o_valid <= 1'b0;
      end

      if (state_nxt == S_DONE)
        o_pass <= (state == S_MONITOR) ? pass_nxt : 1'b0;
      else if ((state != S_IDLE) && i_abort)
        o_pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_bert_sequencer.sv
// Directed bench for lfsr_bert_sequencer: each scenario task drives stimulus and
// compares against hand-derived cycle counts and output values.
module tb_lfsr_bert_sequencer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [7:0]  i_seed = 8'h00;
  logic [3:0]  i_valid_on = 4'd1;
  logic [3:0]  i_valid_off = 4'd0;
  logic [15:0] i_run_cycles = 16'd1;
  logic        i_lock = 1'b0;
  logic [7:0]  o_seed;
  logic        o_soft_reset;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [15:0] o_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_bert_sequencer #(
    .LFSR_WIDTH(8), .SEED_CYCLES(10), .LOCK_TIMEOUT(512), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_seed(i_seed), .i_valid_on(i_valid_on), .i_valid_off(i_valid_off),
    .i_run_cycles(i_run_cycles), .i_lock(i_lock), .o_seed(o_seed),
    .o_soft_reset(o_soft_reset), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_loss_cnt(o_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_test;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({o_seed, o_soft_reset, o_valid, o_busy, o_done, o_pass, o_loss_cnt} !==
        {8'hFF, 5'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_values: seed=%h sr=%b v=%b busy=%b done=%b pass=%b loss=%0d",
               o_seed, o_soft_reset, o_valid, o_busy, o_done, o_pass, o_loss_cnt);
    end
  endtask

  task automatic test_continuous;
    int n = 0;
    int zeros = 0;
    i_seed = 8'hFF; i_valid_on = 4'd1; i_valid_off = 4'd0; i_run_cycles = 16'd256;
    i_lock = 1'b1;
    start_test();
    i_run_cycles = 16'd5;
    i_valid_off = 4'd3;
    while (!o_done && n < 400) begin
      tick();
      n++;
      if (!o_done && n >= 10 && !o_valid) zeros++;
    end
    n_cmp++;
    if (n !== 267) begin n_bad++; $display("FAIL cont_done_cycle: got %0d want 267", n); end
    n_cmp++;
    if (o_pass !== 1'b1) begin n_bad++; $display("FAIL cont_pass: got %b want 1", o_pass); end
    n_cmp++;
    if (o_loss_cnt !== 16'd0) begin n_bad++; $display("FAIL cont_loss: got %0d want 0", o_loss_cnt); end
    n_cmp++;
    if (zeros !== 0) begin n_bad++; $display("FAIL cont_valid_gaps: got %0d want 0", zeros); end
    n_cmp++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL cont_valid_in_done: got %b want 0", o_valid); end
    tick();
    n_cmp++;
    if ({o_busy, o_done, o_pass} !== 3'b001) begin
      n_bad++;
      $display("FAIL cont_after_done: busy/done/pass=%b want 001", {o_busy, o_done, o_pass});
    end
  endtask

  task automatic test_pattern_loss;
    logic [9:0] pat = '0;
    int n = 0;
    i_seed = 8'h3C; i_valid_on = 4'd4; i_valid_off = 4'd1; i_run_cycles = 16'd40;
    i_lock = 1'b1;
    start_test();
    for (int k = 1; k <= 100; k++) begin
      tick();
      n = k;
      if (k >= 10 && k <= 19) pat = {pat[8:0], o_valid};
      i_lock = !(k == 20 || k == 25 || k == 30);
      if (o_done) break;
    end
    i_lock = 1'b1;
    n_cmp++;
    if (pat !== 10'b1111011110) begin n_bad++; $display("FAIL pattern_4_1: got %b want 1111011110", pat); end
    n_cmp++;
    if (n !== 51) begin n_bad++; $display("FAIL pattern_done_cycle: got %0d want 51", n); end
    n_cmp++;
    if (o_loss_cnt !== 16'd3) begin n_bad++; $display("FAIL loss_count: got %0d want 3", o_loss_cnt); end
    n_cmp++;
    if (o_pass !== 1'b0) begin n_bad++; $display("FAIL loss_pass: got %b want 0", o_pass); end
    tick();
  endtask

  task automatic test_seed_zero;
    int cnt = 0;
    int n = 0;
    i_seed = 8'h00; i_valid_on = 4'd1; i_valid_off = 4'd0; i_run_cycles = 16'd4;
    i_lock = 1'b1;
    start_test();
    n_cmp++;
    if (o_seed !== 8'hFF) begin n_bad++; $display("FAIL seed_zero_sub: got %h want ff", o_seed); end
    while (o_soft_reset && cnt < 50) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 10) begin n_bad++; $display("FAIL soft_reset_len: got %0d want 10", cnt); end
    n_cmp++;
    if (o_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", o_valid); end
    while (!o_done && n < 50) begin tick(); n++; end
    n_cmp++;
    if (!o_done || o_pass !== 1'b1) begin
      n_bad++;
      $display("FAIL seed_zero_result: done=%b pass=%b want 1 1", o_done, o_pass);
    end
    tick();
  endtask

  task automatic test_abort;
    int dones = 0;
    logic [4:0] obs = '0;
    i_seed = 8'h81; i_valid_on = 4'd1; i_valid_off = 4'd0; i_run_cycles = 16'd100;
    i_lock = 1'b1;
    start_test();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (o_done) dones++;
      i_lock  = (k != 19);
      i_start = (k == 24);
      i_abort = (k == 29);
      if (k == 30) obs = {o_busy, o_valid, o_soft_reset, o_done, o_pass};
    end
    i_abort = 1'b0;
    i_start = 1'b0;
    n_cmp++;
    if (obs !== 5'b00000) begin
      n_bad++;
      $display("FAIL abort_outputs: busy/valid/sr/done/pass=%b want 00000", obs);
    end
    n_cmp++;
    if (o_loss_cnt !== 16'd1) begin n_bad++; $display("FAIL abort_loss_kept: got %0d want 1", o_loss_cnt); end
    for (int k = 0; k < 150; k++) begin
      tick();
      if (o_done || o_busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", dones); end
  endtask

  task automatic test_abort_beats_start;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    n_cmp++;
    if ({o_busy, o_soft_reset} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_beats_start: busy/sr=%b want 00", {o_busy, o_soft_reset});
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    i_seed = 8'h11; i_valid_on = 4'd2; i_valid_off = 4'd2; i_run_cycles = 16'd10;
    i_lock = 1'b0;
    start_test();
    while (!o_done && n < 700) begin tick(); n++; end
    n_cmp++;
    if (n !== 522) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 522", n); end
    n_cmp++;
    if (o_pass !== 1'b0) begin n_bad++; $display("FAIL timeout_pass: got %b want 0", o_pass); end
    tick();
  endtask

  task automatic test_zero_config;
    int n = 0;
    logic v10 = 1'b0;
    logic v11 = 1'b1;
    i_seed = 8'h42; i_valid_on = 4'd0; i_valid_off = 4'd1; i_run_cycles = 16'd0;
    i_lock = 1'b1;
    start_test();
    while (!o_done && n < 50) begin
      tick();
      n++;
      if (n == 10) v10 = o_valid;
      if (n == 11) v11 = o_valid;
    end
    n_cmp++;
    if (n !== 12) begin n_bad++; $display("FAIL zero_run_cycle: got %0d want 12", n); end
    n_cmp++;
    if ({v10, v11} !== 2'b10) begin n_bad++; $display("FAIL zero_on_pattern: got %b want 10", {v10, v11}); end
    n_cmp++;
    if (o_pass !== 1'b1) begin n_bad++; $display("FAIL zero_cfg_pass: got %b want 1", o_pass); end
    tick();
  endtask

  task automatic test_reset_mid_acquire;
    int n = 0;
    i_seed = 8'h77; i_valid_on = 4'd1; i_valid_off = 4'd0; i_run_cycles = 16'd8;
    i_lock = 1'b0;
    start_test();
    repeat (40) tick();
    n_cmp++;
    if ({o_busy, o_valid} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_acquire: busy/valid=%b want 11", {o_busy, o_valid});
    end
    #2 i_reset = 1'b0;
    #1;
    n_cmp++;
    if ({o_seed, o_soft_reset, o_valid, o_busy, o_done, o_pass, o_loss_cnt} !==
        {8'hFF, 5'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL async_reset_values: seed=%h sr=%b v=%b busy=%b done=%b",
               o_seed, o_soft_reset, o_valid, o_busy, o_done);
    end
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    i_seed = 8'h5A;
    i_lock = 1'b1;
    start_test();
    while (!o_done && n < 50) begin tick(); n++; end
    n_cmp++;
    if (n !== 19) begin n_bad++; $display("FAIL post_reset_cycle: got %0d want 19", n); end
    n_cmp++;
    if ({o_pass, o_seed} !== {1'b1, 8'h5A}) begin
      n_bad++;
      $display("FAIL post_reset_result: pass=%b seed=%h want 1 5a", o_pass, o_seed);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    test_continuous();
    test_pattern_loss();
    test_seed_zero();
    test_abort();
    test_abort_beats_start();
    test_timeout();
    test_zero_config();
    test_reset_mid_acquire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
